ssd_scan: RTL and testbench
===========================

# ssd_scan

Time-multiplexed seven-segment scan controller: shares the single cathode bus among `DIGITS` digit positions. It holds a double-buffered frame of hex nibbles and decimal points, drives one anode at a time for a fixed slot, and inserts an all-off blanking gap between slots to prevent ghosting. It sits between the counter/datapath logic and the board SSD pins, and replaces single-digit direct drive.

## Interface
- `DIGITS`, 8: number of digit positions, 1..8
- `REFRESH_DIV`, 100000: clock cycles each digit is lit, ≥1
- `BLANK_CYCLES`, 1000: clock cycles of all-anodes-off between slots, ≥1
- `ssd_scan_clk`  in  1  system clock
- `ssd_scan_rst_n`  in  1  asynchronous, active-low reset
- `ssd_scan_en`  in  1  scan enable; 0 forces idle, all anodes off
- `ssd_scan_data`  in  4*DIGITS  frame nibbles; digit i at [4i+3:4i]
- `ssd_scan_dp`  in  DIGITS  decimal-point request per digit
- `ssd_scan_mask`  in  DIGITS  1 = digit participates in scan; sampled live
- `ssd_scan_load`  in  1  request to latch data/dp into the shadow frame
- `ssd_scan_ack`  out  1  one-cycle pulse: frame latched
- `ssd_scan_frame`  out  1  one-cycle pulse at each frame boundary
- `ssd_scan_cc`  out  7  segments gfedcba, active-low
- `ssd_scan_odp`  out  1  decimal point, active-low
- `ssd_scan_an`  out  DIGITS  anodes, active-low

## Operation
- States: IDLE, BLANK, SHOW.
- Reset values: state IDLE; `an` all 1; `cc`=7'h7F; `odp`=1; `ack`=0; `frame`=0; shadow frame 0; pending flag 0; pointer DIGITS-1.
- IDLE → BLANK when `en`=1. From any state, `en`=0 → IDLE on the next edge; pointer resets to DIGITS-1; the pending flag is preserved.
- BLANK: all anodes off, `cc`=7'h7F, `odp`=1 for BLANK_CYCLES cycles. On the last cycle:
  - Pointer advances to the next set `mask` bit above the current pointer, wrapping.
  - A wrap, or the first BLANK after IDLE, is a frame boundary.
- SHOW: anode[pointer]=0, `cc`=decode(shadow nibble), `odp`=~shadow dp, for REFRESH_DIV cycles, then BLANK.
- `mask` all zero: the FSM loops in BLANK; every BLANK completion is a frame boundary.
- Load handshake:
  - `load`=1 sets pending.
  - At a frame boundary edge, if pending or `load`=1: shadow ← `data`/`dp` sampled that edge, pending cleared, `ack`=1 the following cycle.
  - The requester holds `data` stable until `ack`.
  - `load` asserted in the `ack` cycle starts a new pending request.
- `frame` pulses in the cycle after every boundary, with or without a load.

## Timing
- All outputs are registered; segments change only on slot transitions, never within SHOW.
- Slot period = BLANK_CYCLES + REFRESH_DIV. Frame period = popcount(mask) × slot period.
- First SHOW anode goes low BLANK_CYCLES+1 cycles after the edge that samples `en`=1 in IDLE.
- Load-to-ack latency: ≤ one frame period + BLANK_CYCLES + 1.
- Reset is asynchronous: outputs take reset values immediately on `rst_n` fall, independent of clock.
- Internal counter width: clog2(max(REFRESH_DIV, BLANK_CYCLES)).

## Configuration
- `SSD_SCAN_LZB_EN` defined: leading-zero blanking.
  - Digit i>0 is suppressed when shadow nibbles i..DIGITS-1 are all zero.
  - A suppressed digit keeps its SHOW slot (uniform timing) but its anode stays 1 and `odp`=1.
  - Digit 0 is never suppressed.
- Undefined: every masked-in digit displays, including zeros.

## Structure
- Package `ssd_scan_pkg`:
  - state enum
  - SEG_OFF constant (7'h7F)
  - hex-to-segment lookup function (0→7'h40, 1→7'h79, …, F→7'h0E)
- One sub-module, `ssd_scan_timer`: loadable down-counter with terminal-count pulse, shared by SHOW and BLANK.

## Test plan
Bench parameters: DIGITS=8, REFRESH_DIV=4, BLANK_CYCLES=2.
- Reset: hold `rst_n` low mid-SHOW, no clock → `an`=8'hFF, `cc`=7'h7F, `odp`=1, `ack`=0 immediately.
- Load 32'h76543210, mask 8'hFF, `en`=1 → `ack` at first boundary; anodes FE,FD,…,7F, each low for 4 cycles with 2-cycle FF gaps; digit 0 `cc`=7'h40; `frame` every 48 cycles.
- Mask 8'h05 → only anodes FE and FB toggle; frame period 12 cycles.
- `load` with new data mid-frame → displayed digits unchanged until the next boundary; `ack` exactly once, in the cycle after that boundary.
- Drop `en` during SHOW of digit 3 → `an`=FF next cycle; re-enable → scan restarts at digit 0 after 2 blank cycles.
- Data 32'h00000120 → with `SSD_SCAN_LZB_EN`, digits 3–7 keep their anodes high in their slots while digit 0 shows `0`; without the macro, all digits light.

Source files
------------

// File: rtl/ssd_scan_pkg.sv
// Shared state encoding, segment constants and hex-to-segment lookup for ssd_scan.
package ssd_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } state_e;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Cathode-side drive for one slot: segments gfedcba and decimal point, both active-low
  typedef struct packed {
    logic [6:0] cc;
    logic       odp;
  } seg_drive_t;

  localparam seg_drive_t SEG_DRIVE_OFF = '{cc: SEG_OFF, odp: 1'b1};

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/ssd_scan_if.sv
// Frame-load handshake and SSD pin bundle between the datapath (master) and ssd_scan (slave).
interface ssd_scan_if #(
  parameter int unsigned DIGITS = 8
);

  logic                  ssd_scan_en;
  logic [4*DIGITS-1:0]   ssd_scan_data;
  logic [DIGITS-1:0]     ssd_scan_dp;
  logic [DIGITS-1:0]     ssd_scan_mask;
  logic                  ssd_scan_load;
  logic                  ssd_scan_ack;
  logic                  ssd_scan_frame;
  logic [6:0]            ssd_scan_cc;
  logic                  ssd_scan_odp;
  logic [DIGITS-1:0]     ssd_scan_an;

  modport master (
    output ssd_scan_en, ssd_scan_data, ssd_scan_dp, ssd_scan_mask, ssd_scan_load,
    input  ssd_scan_ack, ssd_scan_frame, ssd_scan_cc, ssd_scan_odp, ssd_scan_an
  );

  modport slave (
    input  ssd_scan_en, ssd_scan_data, ssd_scan_dp, ssd_scan_mask, ssd_scan_load,
    output ssd_scan_ack, ssd_scan_frame, ssd_scan_cc, ssd_scan_odp, ssd_scan_an
  );

endinterface

// File: rtl/ssd_scan_timer.sv
// Loadable down-counter; tc_c flags the final cycle of the loaded interval (value+1 cycles).
module ssd_scan_timer #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         tc_c
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign tc_c = (cnt == '0);

endmodule

// File: rtl/ssd_scan.sv
// Time-multiplexed seven-segment scan controller with double-buffered frame and blanking gaps.
// Define SSD_SCAN_LZB_EN to suppress leading-zero digits (their slot timing is kept).
module ssd_scan
  import ssd_scan_pkg::*;
#(
  parameter int unsigned DIGITS       = 8,
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 1000
) (
  input  logic          ssd_scan_clk,
  input  logic          ssd_scan_rst_n,
  ssd_scan_if.slave     bus
);

  localparam int unsigned CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned PTR_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(DIGITS - 1);
  localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SHOW_LOAD  = CNT_W'(REFRESH_DIV - 1);

  state_e                 state, state_nxt;
  logic [PTR_W-1:0]       ptr, ptr_adv, ptr_hi, ptr_lo;
  logic                   found_hi, wrap, boundary, take;
  logic                   pending, ack_q, frame_q;
  logic                   tc, tmr_load;
  logic [CNT_W-1:0]       tmr_value;
  logic [DIGITS-1:0][3:0] shadow_data;
  logic [DIGITS-1:0]      shadow_dp;
  logic [DIGITS-1:0]      suppress;
  logic [DIGITS-1:0]      an_q, an_nxt;
  seg_drive_t             seg_q, seg_nxt;

  ssd_scan_timer #(
    .W (CNT_W)
  ) u_timer (
    .clk   (ssd_scan_clk),
    .rst_n (ssd_scan_rst_n),
    .load  (tmr_load),
    .value (tmr_value),
    .tc_c  (tc)
  );

  // Next participating digit strictly above ptr, else wrap to the lowest participating digit
  always_comb begin
    found_hi = 1'b0;
    ptr_hi   = ptr;
    ptr_lo   = ptr;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      if (bus.ssd_scan_mask[i]) begin
        ptr_lo = PTR_W'(i);
        if (i > int'(ptr)) begin
          found_hi = 1'b1;
          ptr_hi   = PTR_W'(i);
        end
      end
    end
    wrap    = ~found_hi;
    ptr_adv = found_hi ? ptr_hi : ptr_lo;
  end

  // State register
  always_ff @(posedge ssd_scan_clk or negedge ssd_scan_rst_n) begin
    if (!ssd_scan_rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; the timer is reloaded on every slot transition and held preloaded in IDLE
  always_comb begin
    state_nxt = state;
    tmr_load  = 1'b0;
    tmr_value = BLANK_LOAD;
    boundary  = 1'b0;
    if (!bus.ssd_scan_en) begin
      state_nxt = ST_IDLE;
      tmr_load  = 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          state_nxt = ST_BLANK;
          tmr_load  = 1'b1;
        end
        ST_BLANK: begin
          if (tc) begin
            tmr_load = 1'b1;
            boundary = wrap;
            if (|bus.ssd_scan_mask) begin
              state_nxt = ST_SHOW;
              tmr_value = SHOW_LOAD;
            end
          end
        end
        ST_SHOW: begin
          if (tc) begin
            state_nxt = ST_BLANK;
            tmr_load  = 1'b1;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  assign take = boundary & (pending | bus.ssd_scan_load);

  // Scan pointer, load handshake and shadow frame
  always_ff @(posedge ssd_scan_clk or negedge ssd_scan_rst_n) begin
    if (!ssd_scan_rst_n) begin
      ptr         <= PTR_LAST;
      pending     <= 1'b0;
      shadow_data <= '0;
      shadow_dp   <= '0;
      ack_q       <= 1'b0;
      frame_q     <= 1'b0;
    end else begin
      if (!bus.ssd_scan_en) begin
        ptr <= PTR_LAST;
      end else if (state == ST_BLANK && tc) begin
        ptr <= ptr_adv;
      end
      pending <= take ? 1'b0 : (pending | bus.ssd_scan_load);
      if (take) begin
        shadow_data <= bus.ssd_scan_data;
        shadow_dp   <= bus.ssd_scan_dp;
      end
      ack_q   <= take;
      frame_q <= boundary;
    end
  end

`ifdef SSD_SCAN_LZB_EN
  logic lz_run;

  // A digit is suppressed when it and every more-significant nibble are zero; digit 0 always shows
  always_comb begin
    suppress = '0;
    lz_run   = 1'b1;
    for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
      lz_run      = lz_run & (shadow_data[i] == 4'h0);
      suppress[i] = lz_run;
    end
  end
`else
  always_comb begin
    suppress = '0;
  end
`endif

  // Output decode; dropping en blanks the pins on the same edge that returns the FSM to IDLE
  always_comb begin
    an_nxt  = '1;
    seg_nxt = SEG_DRIVE_OFF;
    if (bus.ssd_scan_en && state == ST_SHOW && !suppress[ptr]) begin
      an_nxt[ptr] = 1'b0;
      seg_nxt.cc  = seg_decode(shadow_data[ptr]);
      seg_nxt.odp = ~shadow_dp[ptr];
    end
  end

  always_ff @(posedge ssd_scan_clk or negedge ssd_scan_rst_n) begin
    if (!ssd_scan_rst_n) begin
      an_q  <= '1;
      seg_q <= SEG_DRIVE_OFF;
    end else begin
      an_q  <= an_nxt;
      seg_q <= seg_nxt;
    end
  end

  assign bus.ssd_scan_an    = an_q;
  assign bus.ssd_scan_cc    = seg_q.cc;
  assign bus.ssd_scan_odp   = seg_q.odp;
  assign bus.ssd_scan_ack   = ack_q;
  assign bus.ssd_scan_frame = frame_q;

endmodule

// File: tb/tb_ssd_scan.sv
// Randomized scoreboard bench for ssd_scan: a cycle-index model predicts every output vector.
module tb_ssd_scan;

  localparam int DIGITS       = 8;
  localparam int REFRESH_DIV  = 4;
  localparam int BLANK_CYCLES = 2;
  localparam int SLOT         = REFRESH_DIV + BLANK_CYCLES;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  ssd_scan_if #(.DIGITS(DIGITS)) bus ();

  ssd_scan #(
    .DIGITS       (DIGITS),
    .REFRESH_DIV  (REFRESH_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) dut (
    .ssd_scan_clk   (clk),
    .ssd_scan_rst_n (rst_n),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned tag;
    logic [7:0]  an;
    logic [6:0]  cc;
    logic        odp;
    logic        ack;
    logic        frame;
  } exp_t;

  exp_t        q[$];
  int unsigned cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;

  logic [6:0] hex_lut [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference model: position inside the scan is derived from cycles elapsed since enable
  bit          m_run;
  int          m_jc;
  bit          m_pend;
  logic [31:0] m_data;
  logic [7:0]  m_dp;
  logic [7:0]  last_an = 8'hFF;

  logic [7:0]  cur_mask = 8'hFF;
  logic [31:0] cur_data = '0;
  logic [7:0]  cur_dp   = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, want);
    end
  endtask

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].tag <= cyc) begin
      exp_t e;
      e = q.pop_front();
      vectors++;
      if ({bus.ssd_scan_an, bus.ssd_scan_cc, bus.ssd_scan_odp, bus.ssd_scan_ack, bus.ssd_scan_frame}
          !== {e.an, e.cc, e.odp, e.ack, e.frame}) begin
        miscompares++;
        $display("FAIL vec@%0d: got an=%h cc=%h odp=%b ack=%b frame=%b, expected an=%h cc=%h odp=%b ack=%b frame=%b",
                 e.tag, bus.ssd_scan_an, bus.ssd_scan_cc, bus.ssd_scan_odp, bus.ssd_scan_ack,
                 bus.ssd_scan_frame, e.an, e.cc, e.odp, e.ack, e.frame);
      end
    end
  end

  function automatic int nth_set(input logic [7:0] m, input int s);
    int c = 0;
    for (int i = 0; i < 8; i++) begin
      if (m[i]) begin
        if (c == s) return i;
        c++;
      end
    end
    return 0;
  endfunction

  function automatic bit suppressed(input int d);
`ifdef SSD_SCAN_LZB_EN
    return (d > 0) && ((m_data >> (4 * d)) == 32'd0);
`else
    return (d < 0);
`endif
  endfunction

  task automatic m_reset();
    m_run  = 1'b0;
    m_jc   = 0;
    m_pend = 1'b0;
    m_data = '0;
    m_dp   = '0;
  endtask

  task automatic push_off();
    exp_t e;
    e.tag = cyc + 1; e.an = 8'hFF; e.cc = 7'h7F; e.odp = 1'b1; e.ack = 1'b0; e.frame = 1'b0;
    last_an = e.an;
    q.push_back(e);
  endtask

  // Predict the outputs visible after the coming edge, given the inputs sampled at that edge
  task automatic model_step(input logic en, input logic ld);
    exp_t e;
    bit   bnd;
    int   pop, pos, s, d;
    e.tag = cyc + 1; e.an = 8'hFF; e.cc = 7'h7F; e.odp = 1'b1; e.ack = 1'b0; e.frame = 1'b0;
    bnd = 1'b0;
    if (!en) begin
      m_run = 1'b0;
    end else if (!m_run) begin
      m_run = 1'b1;
      m_jc  = 0;
    end else begin
      pop = $countones(cur_mask);
      if (pop == 0) begin
        bnd = (m_jc % BLANK_CYCLES) == BLANK_CYCLES - 1;
      end else begin
        pos = m_jc % SLOT;
        s   = (m_jc / SLOT) % pop;
        if (pos >= BLANK_CYCLES) begin
          d = nth_set(cur_mask, s);
          if (!suppressed(d)) begin
            e.an[d] = 1'b0;
            e.cc    = hex_lut[m_data[4*d +: 4]];
            e.odp   = ~m_dp[d];
          end
        end
        bnd = (pos == BLANK_CYCLES - 1) && (s == 0);
      end
      m_jc++;
    end
    if (bnd) begin
      e.frame = 1'b1;
      if (m_pend || ld) begin
        e.ack  = 1'b1;
        m_data = cur_data;
        m_dp   = cur_dp;
        m_pend = 1'b0;
      end
    end else if (ld) begin
      m_pend = 1'b1;
    end
    last_an = e.an;
    q.push_back(e);
  endtask

  task automatic cycle(input logic en, input logic ld);
    @(negedge clk);
    rst_n             = 1'b1;
    bus.ssd_scan_en   = en;
    bus.ssd_scan_load = ld;
    bus.ssd_scan_mask = cur_mask;
    bus.ssd_scan_data = cur_data;
    bus.ssd_scan_dp   = cur_dp;
    model_step(en, ld);
  endtask

  // Fresh random frame only when no request is outstanding, so data stays stable until ack
  task automatic rand_load(input logic en);
    if (!m_pend) begin
      cur_data = $urandom;
      cur_dp   = 8'($urandom);
    end
    cycle(en, 1'b1);
  endtask

  task automatic async_reset_check();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_an",  32'(bus.ssd_scan_an),  32'hFF);
    chk("rst_cc",  32'(bus.ssd_scan_cc),  32'h7F);
    chk("rst_odp", 32'(bus.ssd_scan_odp), 32'h1);
    chk("rst_ack", 32'(bus.ssd_scan_ack), 32'h0);
    m_reset();
    repeat (3) begin
      @(negedge clk);
      push_off();
    end
  endtask

  initial begin
    bus.ssd_scan_en   = 1'b0;
    bus.ssd_scan_load = 1'b0;
    bus.ssd_scan_mask = 8'hFF;
    bus.ssd_scan_data = '0;
    bus.ssd_scan_dp   = '0;
    m_reset();
    repeat (3) begin
      @(negedge clk);
      push_off();
    end

    // Full eight-digit scan of a known frame
    cur_mask = 8'hFF; cur_data = 32'h76543210; cur_dp = 8'h21;
    cycle(1'b1, 1'b1);
    repeat (150) cycle(1'b1, 1'b0);

    // Asynchronous reset while a digit is lit
    for (int n = 0; n < 20 && last_an == 8'hFF; n++) cycle(1'b1, 1'b0);
    async_reset_check();

    // Sparse mask, then a load landing mid-frame
    cur_mask = 8'h05;
    rand_load(1'b1);
    repeat (40) cycle(1'b1, 1'b0);
    rand_load(1'b1);
    repeat (30) cycle(1'b1, 1'b0);

    // Drop enable while digit 3 is lit, then restart
    cycle(1'b0, 1'b0);
    cur_mask = 8'hFF;
    cycle(1'b1, 1'b0);
    for (int n = 0; n < 60 && last_an != 8'hF7; n++) cycle(1'b1, 1'b0);
    repeat (3) cycle(1'b0, 1'b0);
    repeat (60) cycle(1'b1, 1'b0);

    // Leading zeros in the upper digits
    cur_data = 32'h00000120; cur_dp = 8'h00;
    cycle(1'b1, 1'b1);
    repeat (110) cycle(1'b1, 1'b0);

    // Empty mask: blank loop with a boundary every blank interval
    cycle(1'b0, 1'b0);
    cur_mask = 8'h00;
    rand_load(1'b1);
    repeat (15) cycle(1'b1, 1'b0);
    rand_load(1'b1);
    repeat (10) cycle(1'b1, 1'b0);

    // Random traffic: loads, enable drops, loads while disabled, mask changes while idle
    cycle(1'b0, 1'b0);
    cur_mask = 8'hFF;
    for (int n = 0; n < 1500; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 2) begin
        repeat ($urandom_range(1, 4)) begin
          if ($urandom_range(0, 3) == 0) rand_load(1'b0);
          else cycle(1'b0, 1'b0);
        end
        if ($urandom_range(0, 1) == 1) cur_mask = 8'($urandom);
      end else if (r < 6) begin
        rand_load(1'b1);
      end else begin
        cycle(1'b1, 1'b0);
      end
    end

    repeat (3) @(negedge clk);
    chk("queue_drain", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
